// File: rtl/sync_pkg.sv
// Shared sizing constants for the pulse-read FIFO and its storage.
// Pointer width carries one extra wrap bit above the address bits.
package sync_pkg;

   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned DEPTH_DEF = 8;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DW storage: synchronous write port, registered read port.
// The array itself is never reset; only the read register is.
module fifo_mem
   import sync_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DW-1:0]            rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pulse_rd_fifo.sv
// FIFO popped by single-cycle read strobes; one strobe yields one
// registered word with a one-cycle valid. Sticky overflow/underflow flags.
module pulse_rd_fifo
   import sync_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DW-1:0]           wr_data,
   input  logic                    rd_pulse_i,
   output logic [DW-1:0]           rd_data_o,
   output logic                    rd_valid_o,
   output logic                    full,
   output logic                    empty,
   output logic [ptr_w(DEPTH)-1:0] count_o,
   output logic                    ovf_o,
   output logic                    unf_o
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned AW = PW - 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   // Flags come from the registered pointers, so both are judged before
   // this cycle's read or write takes effect.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count_o = wr_ptr - rd_ptr;

   assign do_wr = wr_en && !full;
   assign do_rd = rd_pulse_i && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rd_valid_o <= 1'b0;
         ovf_o      <= 1'b0;
         unf_o      <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_rd)
            rd_ptr <= rd_ptr + PW'(1);
         rd_valid_o <= do_rd;
         if (wr_en && full)
            ovf_o <= 1'b1;
         if (rd_pulse_i && empty)
            unf_o <= 1'b1;
      end
   end

   fifo_mem #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (do_wr),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (do_rd),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data_o)
   );

endmodule

// File: tb/tb_pulse_rd_fifo.sv
// Directed bench for pulse_rd_fifo (DW=8, DEPTH=8) with immediate assertions.
module tb_pulse_rd_fifo;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_pulse_i;
   logic [7:0] rd_data_o;
   logic       rd_valid_o;
   logic       full;
   logic       empty;
   logic [3:0] count_o;
   logic       ovf_o;
   logic       unf_o;

   int passed = 0;
   int total  = 0;

   logic [7:0] sb [$];
   logic [7:0] exp_word;

   pulse_rd_fifo #(
      .DW    (8),
      .DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_pulse_i (rd_pulse_i),
      .rd_data_o  (rd_data_o),
      .rd_valid_o (rd_valid_o),
      .full       (full),
      .empty      (empty),
      .count_o    (count_o),
      .ovf_o      (ovf_o),
      .unf_o      (unf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(rd_valid_o), 32'd0);
      chk({tag, "_data"},  32'(rd_data_o),  32'd0);
      chk({tag, "_count"}, 32'(count_o),    32'd0);
      chk({tag, "_empty"}, 32'(empty),      32'd1);
      chk({tag, "_full"},  32'(full),       32'd0);
      chk({tag, "_ovf"},   32'(ovf_o),      32'd0);
      chk({tag, "_unf"},   32'(unf_o),      32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      wr_en      = 1'b0;
      wr_data    = '0;
      rd_pulse_i = 1'b0;
      tick();
      tick();
      chk_reset_vals("rst");
      rst = 1'b0;

      // three writes, then pulses four cycles apart
      wr_en = 1'b1; wr_data = 8'h11; tick();
      wr_data = 8'h22; tick();
      wr_data = 8'h33; tick();
      wr_en = 1'b0;
      chk("a_count3", 32'(count_o), 32'd3);
      rd_pulse_i = 1'b1; tick(); rd_pulse_i = 1'b0;
      chk("a_valid1", 32'(rd_valid_o), 32'd1);
      chk("a_data1",  32'(rd_data_o),  32'h11);
      tick();
      chk("a_drop1",  32'(rd_valid_o), 32'd0);
      chk("a_hold1",  32'(rd_data_o),  32'h11);
      tick(); tick();
      rd_pulse_i = 1'b1; tick(); rd_pulse_i = 1'b0;
      chk("a_valid2", 32'(rd_valid_o), 32'd1);
      chk("a_data2",  32'(rd_data_o),  32'h22);
      tick(); tick(); tick();
      rd_pulse_i = 1'b1; tick(); rd_pulse_i = 1'b0;
      chk("a_valid3", 32'(rd_valid_o), 32'd1);
      chk("a_data3",  32'(rd_data_o),  32'h33);
      chk("a_empty",  32'(empty),      32'd1);
      tick();

      // pulse on empty, then write+pulse on empty (no bypass)
      rd_pulse_i = 1'b1; tick(); rd_pulse_i = 1'b0;
      chk("b_unf",    32'(unf_o),      32'd1);
      chk("b_valid0", 32'(rd_valid_o), 32'd0);
      chk("b_hold",   32'(rd_data_o),  32'h33);
      wr_en = 1'b1; wr_data = 8'h5A; rd_pulse_i = 1'b1; tick();
      wr_en = 1'b0; rd_pulse_i = 1'b0;
      chk("b_nobyp",  32'(rd_valid_o), 32'd0);
      chk("b_count1", 32'(count_o),    32'd1);
      rd_pulse_i = 1'b1; tick(); rd_pulse_i = 1'b0;
      chk("b_valid",  32'(rd_valid_o), 32'd1);
      chk("b_data",   32'(rd_data_o),  32'h5A);
      chk("b_ovf0",   32'(ovf_o),      32'd0);

      // fill, overflow, read-while-full, drain back-to-back
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h80 + i); tick();
      end
      chk("c_full",   32'(full),    32'd1);
      chk("c_cnt8",   32'(count_o), 32'd8);
      chk("c_ovf0",   32'(ovf_o),   32'd0);
      wr_data = 8'hAA; tick();
      chk("c_ovf",    32'(ovf_o),   32'd1);
      chk("c_cnt8b",  32'(count_o), 32'd8);
      chk("c_full2",  32'(full),    32'd1);
      wr_data = 8'hBB; rd_pulse_i = 1'b1; tick();
      wr_en = 1'b0;
      chk("c_rwf_v",  32'(rd_valid_o), 32'd1);
      chk("c_rwf_d",  32'(rd_data_o),  32'h80);
      chk("c_cnt7",   32'(count_o),    32'd7);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("c_drain_v", 32'(rd_valid_o), 32'd1);
         chk("c_drain_d", 32'(rd_data_o),  32'(8'h80 + i));
      end
      rd_pulse_i = 1'b0; tick();
      chk("c_valid0", 32'(rd_valid_o), 32'd0);
      chk("c_empty",  32'(empty),      32'd1);

      // simultaneous read/write at count 3
      wr_en = 1'b1;
      wr_data = 8'h01; tick();
      wr_data = 8'h02; tick();
      wr_data = 8'h03; tick();
      wr_data = 8'h77; rd_pulse_i = 1'b1; tick();
      wr_en = 1'b0;
      chk("d_data",   32'(rd_data_o), 32'h01);
      chk("d_cnt3",   32'(count_o),   32'd3);
      tick();
      chk("d_data2",  32'(rd_data_o), 32'h02);
      tick();
      chk("d_data3",  32'(rd_data_o), 32'h03);
      tick();
      rd_pulse_i = 1'b0;
      chk("d_last",   32'(rd_data_o), 32'h77);
      chk("d_lastv",  32'(rd_valid_o), 32'd1);
      chk("d_empty",  32'(empty),     32'd1);

      // 20 interleaved writes/pulses across pointer wrap
      wr_en = 1'b1;
      wr_data = 8'hE0; sb.push_back(wr_data); tick();
      wr_data = 8'hE1; sb.push_back(wr_data); tick();
      for (int i = 0; i < 20; i++) begin
         wr_data    = 8'(8'h30 + i * 7);
         rd_pulse_i = 1'b1;
         exp_word   = sb.pop_front();
         sb.push_back(wr_data);
         tick();
         chk("e_valid", 32'(rd_valid_o), 32'd1);
         chk("e_data",  32'(rd_data_o),  32'(exp_word));
      end
      wr_en = 1'b0;
      chk("e_cnt2", 32'(count_o), 32'd2);
      for (int i = 0; i < 2; i++) begin
         exp_word = sb.pop_front();
         tick();
         chk("e_drain", 32'(rd_data_o), 32'(exp_word));
      end
      rd_pulse_i = 1'b0;
      tick();
      chk("e_empty", 32'(empty), 32'd1);

      // reset with five entries and a pulse pending
      wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(8'h40 + i); tick();
      end
      wr_en = 1'b0;
      chk("f_cnt5",  32'(count_o), 32'd5);
      chk("f_unf",   32'(unf_o),   32'd1);
      chk("f_ovf",   32'(ovf_o),   32'd1);
      rd_pulse_i = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("f_async");
      rd_pulse_i = 1'b0;
      tick();
      rst = 1'b0;
      rd_pulse_i = 1'b1; tick(); rd_pulse_i = 1'b0;
      chk("f_unf2",   32'(unf_o),      32'd1);
      chk("f_valid0", 32'(rd_valid_o), 32'd0);
      chk("f_data0",  32'(rd_data_o),  32'd0);
      chk("f_cnt0",   32'(count_o),    32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pulse_rd_fifo.md
PULSE_RD_FIFO -- requirements
Module: pulse_rd_fifo

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries; a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1, write request; the write is accepted when full=0.
REQ-006 The block SHALL have port wr_data, input, DW, write data, sampled when wr_en=1.
REQ-007 The block SHALL have port rd_pulse_i, input, 1, single-cycle read strobe from the slow-to-fast synchronizer; one pulse means one pop.
REQ-008 The block SHALL have port rd_data_o, output, DW, registered read data.
REQ-009 The block SHALL have port rd_valid_o, output, 1, one-cycle qualifier for rd_data_o.
REQ-010 The block SHALL have port full, output, 1, high when count equals DEPTH.
REQ-011 The block SHALL have port empty, output, 1, high when count equals 0.
REQ-012 The block SHALL have port count_o, output, log2(DEPTH)+1, current occupancy.
REQ-013 The block SHALL have port ovf_o, output, 1, sticky flag: a write was attempted while full.
REQ-014 The block SHALL have port unf_o, output, 1, sticky flag: a read pulse arrived while empty.

Function
REQ-015 A write (wr_en=1, full=0) SHALL store wr_data at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-016 A write while full SHALL be dropped, leave memory and pointers unchanged, and set ovf_o.
REQ-017 A rd_pulse_i while empty=0 SHALL drive the entry at rd_ptr onto rd_data_o and rd_valid_o=1 on the next rising edge (latency 1), then increment rd_ptr modulo DEPTH.
REQ-018 A rd_pulse_i while empty SHALL set unf_o, keep rd_valid_o=0, and leave rd_data_o unchanged.
REQ-019 rd_valid_o SHALL be high for exactly one cycle per accepted pulse; back-to-back pulses SHALL give back-to-back valid words in FIFO order.
REQ-020 rd_data_o SHALL hold its last value while rd_valid_o=0.
REQ-021 Read and write in the same cycle while 0<count<DEPTH SHALL both occur with count unchanged.
REQ-022 Read and write in the same cycle when empty SHALL store the write and flag underflow; there is no write-to-read bypass.
REQ-023 Read and write in the same cycle when full SHALL perform the read only; the write is dropped and sets ovf_o, since full is evaluated before the read.
REQ-024 full, empty and count_o SHALL be registered state-derived values, valid in the cycle after the update.
REQ-025 Pointers SHALL use log2(DEPTH)+1 bits, with the MSB as wrap bit; full and empty SHALL be derived from pointer comparison or count, consistently.
REQ-026 ovf_o and unf_o SHALL remain set until reset.

Reset
REQ-027 Asserting rst SHALL asynchronously clear pointers and count, and drive empty=1, full=0, rd_valid_o=0, rd_data_o=0, ovf_o=0, unf_o=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset mid-operation SHALL discard all stored entries; the first pulse after reset SHALL report underflow.
REQ-030 Deassertion of rst SHALL be synchronized to clk externally; the block SHALL accept a rd_pulse_i on the first clk edge after deassertion.

Structure
REQ-031 DEPTH, DW defaults and the pointer-width function SHALL live in a shared constants package/include, sync_pkg.
REQ-032 Storage SHALL be a sub-module fifo_mem: DEPTH x DW, one synchronous write port and one registered read port; control logic stays in pulse_rd_fifo.

Verification
REQ-033 Reset, then write 0x11, 0x22, 0x33, then three rd_pulse_i spaced 4 cycles apart -> rd_data_o is 0x11, 0x22, 0x33, each with a one-cycle rd_valid_o exactly 1 cycle after its pulse.
REQ-034 Fill 8 words, write 0xAA -> full=1, ovf_o=1, count_o=8; then 8 pulses -> 0xAA never appears.
REQ-035 Empty FIFO, one pulse -> unf_o=1 and rd_valid_o stays 0; next write 0x5A plus pulse -> rd_data_o=0x5A.
REQ-036 count_o=3, simultaneous write 0x77 and pulse -> count_o stays 3, the oldest word is output, and 0x77 is read last.
REQ-037 Write 20 words interleaved with 20 pulses -> pointers wrap and the output order matches a scoreboard with no loss.
REQ-038 Assert rst with count_o=5 while a pulse is in flight -> all outputs are at reset values immediately, and the next pulse reports underflow.
